noc_flit_input_buffer: RTL and testbench

Per-port flit input buffer that sits directly downstream of a Noc_connector sender interface and feeds router input logic.
- Stores flits with their header/tail flags in a first-word-fall-through FIFO.
- Drives upstream VC-ready credit from free space.
- Tracks packet framing, counts complete stored packets and flags protocol violations.

---
 rtl/noc_flit_input_buffer.sv | 143 ++++++++++++++
 tb/tb_noc_flit_input_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_input_buffer.sv
// Flit input buffer: first-word-fall-through FIFO with header/tail flags, credit
// back-pressure toward the upstream sender, packet counting and framing checks.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_flit_input_buffer #(
  parameter int unsigned DATA_WIDTH   = `Noc_Data_Width,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned VC_THRESHOLD = 4
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_flit,
  input  logic                       in_is_header,
  input  logic                       in_is_tail,
  output logic                       in_vc_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_flit,
  output logic                       out_is_header,
  output logic                       out_is_tail,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 2;

  localparam logic [0:0] RX_IDLE   = 1'b0;
  localparam logic [0:0] RX_IN_PKT = 1'b1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THR_C   = CW'(VC_THRESHOLD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PONE_C  = AW'(1);

  // Entry layout: {header, tail, payload}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic [0:0]    state_q, state_d;
  logic          proto_err_q, proto_err_d;

  logic          push;
  logic          pop;
  logic          wr_en;
  logic [EW-1:0] head;

  always_comb begin
    in_ready    = (count_q != DEPTH_C);
    in_vc_ready = ((DEPTH_C - count_q) >= THR_C);
    out_valid   = (count_q != '0);
    head        = mem_q[rd_ptr_q];

    out_flit      = '0;
    out_is_header = 1'b0;
    out_is_tail   = 1'b0;
    if (out_valid) begin
      out_flit      = head[DATA_WIDTH-1:0];
      out_is_tail   = head[DATA_WIDTH];
      out_is_header = head[DATA_WIDTH+1];
    end

    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
  end

  // Framing check: a violating flit is still accepted (in_ready) but never stored.
  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    wr_en       = 1'b0;
    if (push) begin
      if (state_q == RX_IDLE) begin
        if (in_is_header) begin
          wr_en = 1'b1;
          if (!in_is_tail) state_d = RX_IN_PKT;
        end else begin
          proto_err_d = 1'b1;
        end
      end else begin
        if (!in_is_header) begin
          wr_en = 1'b1;
          if (in_is_tail) state_d = RX_IDLE;
        end else begin
          proto_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_en ? (wr_ptr_q + PONE_C) : wr_ptr_q;
    rd_ptr_d    = pop ? (rd_ptr_q + PONE_C) : rd_ptr_q;

    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    pkt_count_d = pkt_count_q;
    case ({wr_en & in_is_tail, pop & out_is_tail})
      2'b10:   pkt_count_d = pkt_count_q + ONE_C;
      2'b01:   pkt_count_d = pkt_count_q - ONE_C;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      state_q     <= RX_IDLE;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_is_header, in_is_tail, in_flit};
  end

  assign pkt_count = pkt_count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_noc_flit_input_buffer.sv
// Directed bench for noc_flit_input_buffer (DATA_WIDTH=32, DEPTH=8, VC_THRESHOLD=4).
module tb_noc_flit_input_buffer;

  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_flit;
  logic        in_is_header;
  logic        in_is_tail;
  logic        in_vc_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_flit;
  logic        out_is_header;
  logic        out_is_tail;
  logic [3:0]  pkt_count;
  logic        proto_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  noc_flit_input_buffer #(
    .DATA_WIDTH  (32),
    .DEPTH       (8),
    .VC_THRESHOLD(4)
  ) dut (
    .noc_clk      (noc_clk),
    .noc_rst      (noc_rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .in_is_header (in_is_header),
    .in_is_tail   (in_is_tail),
    .in_vc_ready  (in_vc_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_flit     (out_flit),
    .out_is_header(out_is_header),
    .out_is_tail  (out_is_tail),
    .pkt_count    (pkt_count),
    .proto_err    (proto_err)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] f, input logic h, input logic t);
    in_valid = 1'b1; in_flit = f; in_is_header = h; in_is_tail = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    noc_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_flit = '0; in_is_header = 1'b0; in_is_tail = 1'b0;
    tick(); tick();
    noc_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_vc_ready !== 1'b1) begin bad++; $display("FAIL rst_vc_ready got=%b exp=1", in_vc_ready); end
    total++; if (pkt_count !== 4'd0) begin bad++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
    total++; if ({out_flit, out_is_header, out_is_tail} !== 34'h0) begin
      bad++; $display("FAIL rst_out_flit got=%h/%b%b exp=0", out_flit, out_is_header, out_is_tail); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] ef [5] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4, 32'hE5};
    logic [1:0]  eh [5] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    push(32'hA1, 1'b1, 1'b0);
    push(32'hB2, 1'b0, 1'b0);
    push(32'hC3, 1'b0, 1'b1);
    total++; if (pkt_count !== 4'd1) begin bad++; $display("FAIL fd_pkt3 got=%0d exp=1", pkt_count); end
    total++; if (in_vc_ready !== 1'b1) begin bad++; $display("FAIL fd_vc3 got=%b exp=1", in_vc_ready); end
    push(32'hD4, 1'b1, 1'b0);
    total++; if (in_vc_ready !== 1'b1) begin bad++; $display("FAIL fd_vc4 got=%b exp=1", in_vc_ready); end
    push(32'hE5, 1'b0, 1'b0);
    total++; if (in_vc_ready !== 1'b0) begin bad++; $display("FAIL fd_vc5 got=%b exp=0", in_vc_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_flit !== ef[i] || {out_is_header, out_is_tail} !== eh[i]) begin
        bad++; $display("FAIL fd_out%0d got=%b %h %b%b exp=1 %h %b", i, out_valid, out_flit,
                        out_is_header, out_is_tail, ef[i], eh[i]); end
      tick();
      total++; if (pkt_count !== ((i >= 2) ? 4'd0 : 4'd1)) begin
        bad++; $display("FAIL fd_pkt_pop%0d got=%0d exp=%0d", i, pkt_count, (i >= 2) ? 0 : 1); end
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fd_empty got=%b exp=0", out_valid); end
  endtask

  // Receiver is still inside the D4 packet: first flit closes it with a body tail.
  task automatic test_full();
    push(32'h10, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) push(32'h10 + 32'(i), 1'b1, 1'b1);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    total++; if (in_vc_ready !== 1'b0) begin bad++; $display("FAIL full_vc got=%b exp=0", in_vc_ready); end
    total++; if (pkt_count !== 4'd8) begin bad++; $display("FAIL full_pkt got=%0d exp=8", pkt_count); end
    in_valid = 1'b1; in_flit = 32'h99; in_is_header = 1'b1; in_is_tail = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_in_ready got=%b exp=1", in_ready); end
    total++; if (pkt_count !== 4'd7) begin bad++; $display("FAIL full_pop_pkt got=%0d exp=7", pkt_count); end
    for (int i = 1; i < 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_flit !== 32'h10 + 32'(i)) begin
        bad++; $display("FAIL full_drain%0d got=%b %h exp=1 %h", i, out_valid, out_flit, 32'h10 + 32'(i)); end
      tick();
    end
    total++; if (out_valid !== 1'b0 || pkt_count !== 4'd0) begin
      bad++; $display("FAIL full_drained got=%b %0d exp=0 0 (0x99 must not be stored)", out_valid, pkt_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_flit = 32'h200 + 32'(k);
      in_is_header = (k == 0); in_is_tail = (k == 5);
      tick();
      total++; if (out_valid !== 1'b1 || out_flit !== 32'h200 + 32'(k) ||
                   out_is_header !== (k == 0) || out_is_tail !== (k == 5) || in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got=%b %h %b%b rdy=%b exp=1 %h", k, out_valid, out_flit,
                        out_is_header, out_is_tail, in_ready, 32'h200 + 32'(k)); end
      total++; if (in_vc_ready !== 1'b1) begin bad++; $display("FAIL b2b_vc%0d got=%b exp=1", k, in_vc_ready); end
    end
    in_valid = 1'b0;
    total++; if (pkt_count !== 4'd1) begin bad++; $display("FAIL b2b_pkt got=%0d exp=1", pkt_count); end
    tick();
    total++; if (out_valid !== 1'b0 || pkt_count !== 4'd0) begin
      bad++; $display("FAIL b2b_end got=%b %0d exp=0 0", out_valid, pkt_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_proto_idle();
    push(32'h55, 1'b0, 1'b0);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL pe_idle_err got=%b exp=1", proto_err); end
    total++; if (out_valid !== 1'b0 || out_flit !== 32'h0) begin
      bad++; $display("FAIL pe_idle_drop got=%b %h exp=0 0", out_valid, out_flit); end
    push(32'h66, 1'b1, 1'b1);
    total++; if (out_flit !== 32'h66 || {out_is_header, out_is_tail} !== 2'b11 || pkt_count !== 4'd1) begin
      bad++; $display("FAIL pe_idle_next got=%h %b%b %0d exp=66 11 1", out_flit, out_is_header, out_is_tail, pkt_count); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || proto_err !== 1'b1) begin
      bad++; $display("FAIL pe_idle_sticky got=%b %b exp=0 1", out_valid, proto_err); end
  endtask

  task automatic test_proto_in_pkt();
    do_reset();
    push(32'h31, 1'b1, 1'b0);
    push(32'h32, 1'b1, 1'b0);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL pe_pkt_err got=%b exp=1", proto_err); end
    push(32'h33, 1'b0, 1'b1);
    out_ready = 1'b1;
    total++; if (out_flit !== 32'h31) begin bad++; $display("FAIL pe_pkt_h got=%h exp=31", out_flit); end
    tick();
    total++; if (out_flit !== 32'h33 || out_is_tail !== 1'b1) begin
      bad++; $display("FAIL pe_pkt_t got=%h %b exp=33 1", out_flit, out_is_tail); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pe_pkt_empty got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(32'h77, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b exp=1", out_valid); end
    noc_rst = 1'b1; tick(); noc_rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_flit !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rm_clear got=%b %h %b exp=0 0 1", out_valid, out_flit, in_ready); end
    push(32'h88, 1'b0, 1'b0);
    total++; if (proto_err !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rm_idle got=%b %b exp=1 0", proto_err, out_valid); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full();
    test_back_to_back();
    test_proto_idle();
    test_proto_in_pkt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
